mem_stage: RTL

Memory stage of the five-stage RISC-V pipeline. Consumes the EX/MEM pipeline register outputs, performs byte-addressable little-endian data-memory loads and stores (byte/half/word, signed/unsigned), and registers the result into the MEM/WB pipeline register feeding write-back. Also provides stall and flush control for the MEM/WB register.

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/mem_stage_if.sv | 39 +++
 rtl/mem_stage_dmem.sv | 32 +++
 rtl/mem_stage.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: result-select codes, funct3 access
// codes and helpers that decode the access size.
package mem_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    // Unlisted load encodings behave as LW.
    function automatic acc_size_e load_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: load_size = SZ_BYTE;
            F3_H, F3_HU: load_size = SZ_HALF;
            default:     load_size = SZ_WORD;
        endcase
    endfunction

    function automatic acc_size_e store_size(input logic [2:0] f3);
        case (f3)
            F3_B:    store_size = SZ_BYTE;
            F3_H:    store_size = SZ_HALF;
            default: store_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [1:0] align_mask(input acc_size_e sz);
        case (sz)
            SZ_HALF: align_mask = 2'b01;
            SZ_WORD: align_mask = 2'b11;
            default: align_mask = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, stall/flush control and MEM/WB outputs of the memory stage.
interface mem_stage_if #(
    parameter int DATA_LENGTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int REG_LENGTH  = 5
);
    logic [DATA_LENGTH-1:0] alu_res_in;
    logic [DATA_LENGTH-1:0] w_data_in;
    logic [REG_LENGTH-1:0]  rd_in;
    logic [PC_WIDTH-1:0]    pc_plus4_in;
    logic [2:0]             funct3_in;
    logic                   reg_write_in;
    logic [1:0]             result_src_in;
    logic                   mem_write_in;
    logic                   stall_in;
    logic                   flush_in;

    logic [DATA_LENGTH-1:0] alu_res_out;
    logic [DATA_LENGTH-1:0] read_data_out;
    logic [REG_LENGTH-1:0]  rd_out;
    logic [PC_WIDTH-1:0]    pc_plus4_out;
    logic                   reg_write_out;
    logic [1:0]             result_src_out;
    logic                   misalign_out;

    modport master (
        output alu_res_in, w_data_in, rd_in, pc_plus4_in, funct3_in,
               reg_write_in, result_src_in, mem_write_in, stall_in, flush_in,
        input  alu_res_out, read_data_out, rd_out, pc_plus4_out,
               reg_write_out, result_src_out, misalign_out
    );

    modport slave (
        input  alu_res_in, w_data_in, rd_in, pc_plus4_in, funct3_in,
               reg_write_in, result_src_in, mem_write_in, stall_in, flush_in,
        output alu_res_out, read_data_out, rd_out, pc_plus4_out,
               reg_write_out, result_src_out, misalign_out
    );
endinterface

// File: rtl/mem_stage_dmem.sv
// Byte-wide data memory: byte-enabled synchronous write, combinational
// 32-bit little-endian read. Multi-byte accesses wrap inside the array.
module dmem #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [31:0]           rdata_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0] mem_q [DEPTH];

    // Write lane i to base+i; the ADDR_WIDTH-bit sum wraps around the array.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[waddr_i + ADDR_WIDTH'(i)] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Gather four consecutive bytes starting at the read base.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata_o[8*i +: 8] = mem_q[raddr_i + ADDR_WIDTH'(i)];
        end
    end
endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage: data-memory access, load extension and MEM/WB register.
// Optional macro DMEM_MISALIGN_CHECK_EN flags misaligned accesses instead of aligning them.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_LENGTH     = 32,
    parameter int PC_WIDTH        = 32,
    parameter int REG_LENGTH      = 5,
    parameter int DMEM_ADDR_WIDTH = 12
) (
    input logic       clk,
    input logic       rst,
    mem_stage_if.slave bus
);
    logic [DMEM_ADDR_WIDTH-1:0] idx_s;
    logic [DMEM_ADDR_WIDTH-1:0] ld_addr_s;
    logic [DMEM_ADDR_WIDTH-1:0] st_addr_s;
    acc_size_e                  ld_size_s;
    acc_size_e                  st_size_s;
    logic                       is_load_s;
    logic                       misalign_s;
    logic                       st_en_s;
    logic [3:0]                 be_raw_s;
    logic [3:0]                 be_s;
    logic [31:0]                rdata_s;
    logic [DATA_LENGTH-1:0]     ld_ext_s;
    logic                       unused_s;

    logic [DATA_LENGTH-1:0] alu_res_d,   alu_res_q;
    logic [DATA_LENGTH-1:0] read_data_d, read_data_q;
    logic [REG_LENGTH-1:0]  rd_d,        rd_q;
    logic [PC_WIDTH-1:0]    pc_plus4_d,  pc_plus4_q;
    logic                   reg_write_d, reg_write_q;
    logic [1:0]             result_src_d, result_src_q;
    logic                   misalign_d,  misalign_q;

    assign unused_s = ^bus.alu_res_in[DATA_LENGTH-1:DMEM_ADDR_WIDTH];

    // Address decode, alignment policy and store byte enables.
    always_comb begin
        idx_s     = bus.alu_res_in[DMEM_ADDR_WIDTH-1:0];
        is_load_s = (bus.result_src_in == RES_MEM);
        ld_size_s = load_size(bus.funct3_in);
        st_size_s = store_size(bus.funct3_in);
`ifdef DMEM_MISALIGN_CHECK_EN
        ld_addr_s  = idx_s;
        st_addr_s  = idx_s;
        misalign_s = (is_load_s && ((idx_s[1:0] & align_mask(ld_size_s)) != 2'b00)) ||
                     (bus.mem_write_in && ((idx_s[1:0] & align_mask(st_size_s)) != 2'b00));
`else
        ld_addr_s  = {idx_s[DMEM_ADDR_WIDTH-1:2], idx_s[1:0] & ~align_mask(ld_size_s)};
        st_addr_s  = {idx_s[DMEM_ADDR_WIDTH-1:2], idx_s[1:0] & ~align_mask(st_size_s)};
        misalign_s = 1'b0;
`endif
        // A store also dies while reset is held so it never lands on the reset edge.
        st_en_s = bus.mem_write_in && !bus.stall_in && !bus.flush_in && !misalign_s && rst;
        case (st_size_s)
            SZ_BYTE: be_raw_s = 4'b0001;
            SZ_HALF: be_raw_s = 4'b0011;
            default: be_raw_s = 4'b1111;
        endcase
        be_s = be_raw_s & {4{st_en_s}};
    end

    // Sign/zero extension of the raw little-endian read word.
    always_comb begin
        case (bus.funct3_in)
            F3_B:    ld_ext_s = {{(DATA_LENGTH-8){rdata_s[7]}}, rdata_s[7:0]};
            F3_H:    ld_ext_s = {{(DATA_LENGTH-16){rdata_s[15]}}, rdata_s[15:0]};
            F3_BU:   ld_ext_s = {{(DATA_LENGTH-8){1'b0}}, rdata_s[7:0]};
            F3_HU:   ld_ext_s = {{(DATA_LENGTH-16){1'b0}}, rdata_s[15:0]};
            default: ld_ext_s = DATA_LENGTH'(rdata_s);
        endcase
    end

    dmem #(
        .ADDR_WIDTH(DMEM_ADDR_WIDTH)
    ) u_dmem (
        .clk_i  (clk),
        .be_i   (be_s),
        .waddr_i(st_addr_s),
        .wdata_i(bus.w_data_in[31:0]),
        .raddr_i(ld_addr_s),
        .rdata_o(rdata_s)
    );

    // Next MEM/WB contents for a normal (unstalled, unflushed) cycle.
    always_comb begin
        alu_res_d    = bus.alu_res_in;
        read_data_d  = (is_load_s && !misalign_s) ? ld_ext_s : {DATA_LENGTH{1'b0}};
        rd_d         = bus.rd_in;
        pc_plus4_d   = bus.pc_plus4_in;
        reg_write_d  = bus.reg_write_in && !misalign_s;
        result_src_d = bus.result_src_in;
        misalign_d   = misalign_s;
    end

    // MEM/WB register: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_res_q    <= {DATA_LENGTH{1'b0}};
            read_data_q  <= {DATA_LENGTH{1'b0}};
            rd_q         <= {REG_LENGTH{1'b0}};
            pc_plus4_q   <= {PC_WIDTH{1'b0}};
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            misalign_q   <= 1'b0;
        end else if (bus.flush_in) begin
            alu_res_q    <= {DATA_LENGTH{1'b0}};
            read_data_q  <= {DATA_LENGTH{1'b0}};
            rd_q         <= {REG_LENGTH{1'b0}};
            pc_plus4_q   <= {PC_WIDTH{1'b0}};
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            misalign_q   <= 1'b0;
        end else if (!bus.stall_in) begin
            alu_res_q    <= alu_res_d;
            read_data_q  <= read_data_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            misalign_q   <= misalign_d;
        end
    end

    assign bus.alu_res_out    = alu_res_q;
    assign bus.read_data_out  = read_data_q;
    assign bus.rd_out         = rd_q;
    assign bus.pc_plus4_out   = pc_plus4_q;
    assign bus.reg_write_out  = reg_write_q;
    assign bus.result_src_out = result_src_q;
    assign bus.misalign_out   = misalign_q;
endmodule
